// File: rtl/btn_conditioner.sv
// btn_conditioner
// Front-end conditioner between raw board pushbuttons/switches and the SLC-3
// core. Brings every asynchronous input into the Clk domain through a two-flop
// synchronizer. Each button is also debounced by its own small FSM, which
// produces a clean level plus single-cycle press/release pulses. A physical
// press therefore gives exactly one Run/Continue event in the core.
//
// Per-channel debounce FSM:
//   STABLE_LO -> WAIT_HI when the synchronized input goes high (cnt = 1)
//   WAIT_HI   -> STABLE_LO on any low sample (bounce rejected, no pulse)
//   WAIT_HI   -> STABLE_HI once cnt reaches DEBOUNCE_CYCLES-1 with the input
//                still high (level set, one-cycle press pulse)
//   STABLE_HI / WAIT_LO mirror the above with the polarity inverted.
// The counter only moves in the WAIT states and never passes
// DEBOUNCE_CYCLES-1, so it cannot wrap.
//
// dbg_state carries each channel's FSM state (2 bits per channel, channel 0
// in the low bits) so that external checkers can observe it.

module btn_conditioner #(
  parameter int NUM_BTN         = 2,
  parameter int SW_WIDTH        = 16,
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic [NUM_BTN-1:0]   btn_raw,
  input  logic [SW_WIDTH-1:0]  sw_raw,
  output logic [NUM_BTN-1:0]   btn_level,
  output logic [NUM_BTN-1:0]   btn_press,
  output logic [NUM_BTN-1:0]   btn_release,
  output logic [SW_WIDTH-1:0]  sw_sync,
  output logic [2*NUM_BTN-1:0] dbg_state
);

  // The counter width leaves one bit of headroom above DEBOUNCE_CYCLES-1.
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    WAIT_HI   = 2'd1,
    STABLE_HI = 2'd2,
    WAIT_LO   = 2'd3
  } btn_state_e;

  logic [SW_WIDTH-1:0] sw_s1;
  logic [NUM_BTN-1:0]  btn_s1;
  logic [NUM_BTN-1:0]  btn_s2;

  // Two-flop synchronizer for the switch bus. There is no debounce here;
  // the core simply sees the switches two cycles late.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      sw_s1   <= '0;
      sw_sync <= '0;
    end else begin
      sw_s1   <= sw_raw;
      sw_sync <= sw_s1;
    end
  end

  // Two-flop synchronizer for the buttons. btn_s2 feeds the debounce FSMs.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      btn_s1 <= '0;
      btn_s2 <= '0;
    end else begin
      btn_s1 <= btn_raw;
      btn_s2 <= btn_s1;
    end
  end

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    btn_state_e       state_q;
    btn_state_e       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             level_q;
    logic             level_d;
    logic             press_q;
    logic             press_d;
    logic             rel_q;
    logic             rel_d;
    logic             s2;
    logic             cnt_done;

    assign s2       = btn_s2[g];
    assign cnt_done = (cnt_q == CNT_LAST);

    // State register, together with the stability counter and the
    // registered level/pulse outputs.
    always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
        state_q <= STABLE_LO;
        cnt_q   <= '0;
        level_q <= 1'b0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        level_q <= level_d;
        press_q <= press_d;
        rel_q   <= rel_d;
      end
    end

    // Next-state logic. Any sample that disagrees with the level being
    // waited for sends the FSM back to its stable state.
    always_comb begin
      state_d = state_q;
      case (state_q)
        STABLE_LO: if (s2)          state_d = WAIT_HI;
        WAIT_HI: begin
          if (!s2)                  state_d = STABLE_LO;
          else if (cnt_done)        state_d = STABLE_HI;
        end
        STABLE_HI: if (!s2)         state_d = WAIT_LO;
        WAIT_LO: begin
          if (s2)                   state_d = STABLE_HI;
          else if (cnt_done)        state_d = STABLE_LO;
        end
        default:                    state_d = STABLE_LO;
      endcase
    end

    // Output logic: the next counter value, the next level, and the
    // one-cycle pulses raised only on the accepting transition.
    always_comb begin
      cnt_d   = '0;
      level_d = level_q;
      press_d = 1'b0;
      rel_d   = 1'b0;
      case (state_q)
        STABLE_LO: begin
          if (s2) cnt_d = CNT_ONE;
        end
        WAIT_HI: begin
          if (s2) begin
            if (cnt_done) begin
              level_d = 1'b1;
              press_d = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end
        end
        STABLE_HI: begin
          if (!s2) cnt_d = CNT_ONE;
        end
        WAIT_LO: begin
          if (!s2) begin
            if (cnt_done) begin
              level_d = 1'b0;
              rel_d   = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end
        end
        default: begin
          level_d = 1'b0;
        end
      endcase
    end

    assign btn_level[g]         = level_q;
    assign btn_press[g]         = press_q;
    assign btn_release[g]       = rel_q;
    assign dbg_state[2*g +: 2]  = state_q;
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner with a short debounce window (4 cycles).
// The reference model keeps a history of sampled raw bits for each button.
// A button's level flips when the samples that the synchronizer delivers over
// the last D edges all disagree with the current level. Switches are modelled
// as a plain two-edge delay.

module tb_btn_conditioner;

  localparam int NB  = 2;
  localparam int SWW = 16;
  localparam int D   = 4;

  logic            Clk;
  logic            Reset;
  logic [NB-1:0]   btn_raw;
  logic [SWW-1:0]  sw_raw;
  logic [NB-1:0]   btn_level;
  logic [NB-1:0]   btn_press;
  logic [NB-1:0]   btn_release;
  logic [SWW-1:0]  sw_sync;
  logic [2*NB-1:0] dbg_state;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [15:0]    hist [NB];
  logic [NB-1:0]  m_level;
  logic [NB-1:0]  m_press;
  logic [NB-1:0]  m_release;
  logic [SWW-1:0] m_sw_s1;
  logic [SWW-1:0] m_sw_sync;

  btn_conditioner #(
    .NUM_BTN         (NB),
    .SW_WIDTH        (SWW),
    .DEBOUNCE_CYCLES (D)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .btn_raw     (btn_raw),
    .sw_raw      (sw_raw),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .sw_sync     (sw_sync),
    .dbg_state   (dbg_state)
  );

  // Clock
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Overall time limit
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach its summary");
    $fatal(1);
  end

  function automatic void model_clear();
    for (int b = 0; b < NB; b++) hist[b] = '0;
    m_level   = '0;
    m_press   = '0;
    m_release = '0;
    m_sw_s1   = '0;
    m_sw_sync = '0;
  endfunction

  // One rising edge of the reference. Inputs hold their pre-edge values here.
  function automatic void model_edge();
    bit all_hi;
    bit all_lo;
    if (!Reset) begin
      model_clear();
    end else begin
      m_sw_sync = m_sw_s1;
      m_sw_s1   = sw_raw;
      for (int b = 0; b < NB; b++) begin
        hist[b] = {hist[b][14:0], btn_raw[b]};
        all_hi = 1'b1;
        all_lo = 1'b1;
        // bit i holds the raw value sampled i edges ago; the synchronizer
        // output seen at this edge is the one sampled two edges ago
        for (int i = 2; i <= D + 1; i++) begin
          if (hist[b][i]) all_lo = 1'b0;
          else            all_hi = 1'b0;
        end
        m_press[b]   = 1'b0;
        m_release[b] = 1'b0;
        if (!m_level[b] && all_hi) begin
          m_level[b] = 1'b1;
          m_press[b] = 1'b1;
        end else if (m_level[b] && all_lo) begin
          m_level[b]   = 1'b0;
          m_release[b] = 1'b1;
        end
      end
    end
  endfunction

  // Advance one clock and leave the bench 1 time unit after the edge
  task automatic step();
    @(posedge Clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    Reset   = 1'b0;
    btn_raw = '0;
    sw_raw  = '0;
    model_clear();
    step();
    step();
    checks++;
    if ({btn_level, btn_press, btn_release, sw_sync} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: level=%b press=%b release=%b sw=%h, expected all zero",
               btn_level, btn_press, btn_release, sw_sync);
    end
    checks++;
    if (dbg_state !== '0) begin
      errors++;
      $display("FAIL reset_state: dbg_state=%b, expected all STABLE_LO (0)", dbg_state);
    end
    Reset = 1'b1;
    for (int c = 0; c < 20; c++) begin
      step();
      checks++;
      if ({btn_level, btn_press, btn_release, sw_sync} !== {m_level, m_press, m_release, m_sw_sync}
          || {btn_level, btn_press, btn_release, sw_sync} !== '0) begin
        errors++;
        $display("FAIL idle_after_reset cyc %0d: level=%b press=%b release=%b sw=%h, expected zero",
                 c, btn_level, btn_press, btn_release, sw_sync);
      end
    end
  endtask

  task automatic test_sw_sync();
    sw_raw = 16'h005A;
    step();  // edge k samples the new value
    checks++;
    if (sw_sync !== 16'h0000) begin
      errors++;
      $display("FAIL sw_early: sw_sync=%h after edge k, expected 0000", sw_sync);
    end
    step();  // edge k+1
    checks++;
    if (sw_sync !== 16'h005A || sw_sync !== m_sw_sync) begin
      errors++;
      $display("FAIL sw_latency: sw_sync=%h after edge k+1, expected 005a", sw_sync);
    end
  endtask

  task automatic test_press();
    int n;
    int extra;
    bit seen;
    btn_raw[0] = 1'b1;
    step();  // edge k
    n = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      step();
      n++;
      checks++;
      if ({btn_level, btn_press, btn_release, sw_sync} !== {m_level, m_press, m_release, m_sw_sync}) begin
        errors++;
        $display("FAIL press_model step %0d: level=%b press=%b release=%b, expected level=%b press=%b release=%b",
                 n, btn_level, btn_press, btn_release, m_level, m_press, m_release);
      end
      if (btn_press[0]) seen = 1'b1;
    end
    checks++;
    if (!seen || n != D + 1) begin
      errors++;
      $display("FAIL press_latency: press seen=%0d after %0d edges, expected after %0d", seen, n, D + 1);
    end
    checks++;
    if (btn_level !== 2'b01) begin
      errors++;
      $display("FAIL press_level: btn_level=%b, expected 01", btn_level);
    end
    extra = 0;
    for (int c = 0; c < 50; c++) begin
      step();
      if (btn_press[0]) extra++;
      checks++;
      if ({btn_level, btn_press, btn_release} !== {m_level, m_press, m_release}) begin
        errors++;
        $display("FAIL hold_model cyc %0d: level=%b press=%b release=%b, expected level=%b press=%b release=%b",
                 c, btn_level, btn_press, btn_release, m_level, m_press, m_release);
      end
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL no_autorepeat: %0d extra presses while held, expected 0", extra);
    end
  endtask

  task automatic test_bounce();
    logic [5:0] pat;
    int n;
    bit seen;
    pat = 6'b101101;  // applied MSB first: 1,0,1,1,0,1
    for (int i = 5; i >= 0; i--) begin
      btn_raw[1] = pat[i];
      step();
      checks++;
      if (btn_press[1] !== 1'b0 || btn_level[1] !== 1'b0
          || {btn_level, btn_press, btn_release} !== {m_level, m_press, m_release}) begin
        errors++;
        $display("FAIL bounce_quiet elem %0d: level=%b press=%b, expected level[1]=0 press[1]=0",
                 5 - i, btn_level, btn_press);
      end
    end
    // the last 1 of the pattern stays applied: it was first sampled at edge k
    n = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      step();
      n++;
      checks++;
      if ({btn_level, btn_press, btn_release} !== {m_level, m_press, m_release}) begin
        errors++;
        $display("FAIL bounce_model step %0d: level=%b press=%b release=%b, expected level=%b press=%b release=%b",
                 n, btn_level, btn_press, btn_release, m_level, m_press, m_release);
      end
      if (btn_press[1]) seen = 1'b1;
    end
    checks++;
    if (!seen || n != D + 1) begin
      errors++;
      $display("FAIL bounce_latency: press seen=%0d after %0d edges, expected after %0d", seen, n, D + 1);
    end
  endtask

  task automatic test_release();
    int n;
    int rels;
    bit seen;
    btn_raw[0] = 1'b0;
    step();  // edge k
    n = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      step();
      n++;
      checks++;
      if ({btn_level, btn_press, btn_release} !== {m_level, m_press, m_release}) begin
        errors++;
        $display("FAIL release_model step %0d: level=%b press=%b release=%b, expected level=%b press=%b release=%b",
                 n, btn_level, btn_press, btn_release, m_level, m_press, m_release);
      end
      if (btn_release[0]) seen = 1'b1;
    end
    checks++;
    if (!seen || n != D + 1 || btn_level[0] !== 1'b0) begin
      errors++;
      $display("FAIL release_latency: release seen=%0d after %0d edges level0=%b, expected after %0d level0=0",
               seen, n, btn_level[0], D + 1);
    end
    // press again, then a 2-cycle low glitch must not release
    btn_raw[0] = 1'b1;
    for (int c = 0; c < 12; c++) step();
    checks++;
    if (btn_level[0] !== 1'b1 || m_level[0] !== 1'b1) begin
      errors++;
      $display("FAIL repress_level: level0=%b, expected 1", btn_level[0]);
    end
    rels = 0;
    btn_raw[0] = 1'b0;
    step();
    if (btn_release[0]) rels++;
    step();
    if (btn_release[0]) rels++;
    btn_raw[0] = 1'b1;
    for (int c = 0; c < 20; c++) begin
      step();
      if (btn_release[0]) rels++;
      checks++;
      if ({btn_level, btn_press, btn_release} !== {m_level, m_press, m_release}) begin
        errors++;
        $display("FAIL glitch_model cyc %0d: level=%b press=%b release=%b, expected level=%b press=%b release=%b",
                 c, btn_level, btn_press, btn_release, m_level, m_press, m_release);
      end
    end
    checks++;
    if (rels != 0 || btn_level[0] !== 1'b1) begin
      errors++;
      $display("FAIL glitch_rejected: %0d releases level0=%b, expected 0 releases level0=1", rels, btn_level[0]);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    bit seen;
    // bring channel 0 low first; channel 1 is still held high
    btn_raw[0] = 1'b0;
    for (int c = 0; c < 12; c++) step();
    btn_raw[0] = 1'b1;
    step();  // edge k samples the press
    step();  // k+1
    step();  // k+2: WAIT_HI, cnt=1
    step();  // k+3: cnt=2
    Reset = 1'b0;
    model_clear();
    #1;
    checks++;
    if ({btn_level, btn_press, btn_release, sw_sync} !== '0) begin
      errors++;
      $display("FAIL async_reset: level=%b press=%b release=%b sw=%h, expected all zero immediately",
               btn_level, btn_press, btn_release, sw_sync);
    end
    step();
    Reset = 1'b1;  // released just after this edge (edge 0)
    n = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      step();
      n++;
      checks++;
      if ({btn_level, btn_press, btn_release, sw_sync} !== {m_level, m_press, m_release, m_sw_sync}) begin
        errors++;
        $display("FAIL post_reset_model step %0d: level=%b press=%b release=%b sw=%h, expected level=%b press=%b release=%b sw=%h",
                 n, btn_level, btn_press, btn_release, sw_sync, m_level, m_press, m_release, m_sw_sync);
      end
      if (btn_press[0]) seen = 1'b1;
    end
    checks++;
    if (!seen || n != D + 2) begin
      errors++;
      $display("FAIL fresh_press: press seen=%0d after %0d edges from release, expected after %0d", seen, n, D + 2);
    end
  endtask

  task automatic test_random();
    int hold [NB];
    for (int b = 0; b < NB; b++) hold[b] = 1;
    for (int c = 0; c < 600; c++) begin
      for (int b = 0; b < NB; b++) begin
        hold[b]--;
        if (hold[b] <= 0) begin
          btn_raw[b] = ~btn_raw[b];
          hold[b] = $urandom_range(1, 2 * D + 2);
        end
      end
      if ($urandom_range(0, 15) == 0) sw_raw = SWW'($urandom);
      step();
      checks++;
      if ({btn_level, btn_press, btn_release, sw_sync} !== {m_level, m_press, m_release, m_sw_sync}) begin
        errors++;
        $display("FAIL random_model cyc %0d: level=%b press=%b release=%b sw=%h, expected level=%b press=%b release=%b sw=%h",
                 c, btn_level, btn_press, btn_release, sw_sync, m_level, m_press, m_release, m_sw_sync);
      end
      checks++;
      if ((btn_press & btn_release) !== '0) begin
        errors++;
        $display("FAIL pulse_exclusive cyc %0d: press=%b release=%b, expected no overlap",
                 c, btn_press, btn_release);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sw_sync();
    test_press();
    test_bounce();
    test_release();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
